// File: rtl/frogger_pkg.sv
// Shared Frogger playfield constants, scheduler state encoding and column helpers.
package frogger_pkg;

    localparam int GRID_COLS = 20;
    localparam int GRID_ROWS = 15;
    localparam int CELL_PX   = 32;

    localparam int COL_W    = 5;
    localparam int ROW_W    = 4;
    localparam int PERIOD_W = 4;

    localparam logic [COL_W-1:0] COL_MAX = COL_W'(GRID_COLS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } sched_state_t;

    // A programmed period of 0 means "move on every tick".
    function automatic logic [PERIOD_W-1:0] eff_period(input logic [PERIOD_W-1:0] p);
        return (p == '0) ? PERIOD_W'(1) : p;
    endfunction

    // One column step along a row, wrapping at either edge of the grid.
    function automatic logic [COL_W-1:0] next_col(input logic [COL_W-1:0] x,
                                                  input logic             dir);
        logic [COL_W-1:0] r;
        if (!dir) begin
            r = (x == COL_MAX) ? '0 : x + COL_W'(1);
        end else begin
            r = (x == '0) ? COL_MAX : x - COL_W'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: a registered one-cycle tick every TICK_CYCLES clocks.
module tick_gen #(
    parameter int TICK_CYCLES = 5000000
) (
    input  logic i_Clk,
    input  logic i_Rst_n,
    output logic tick
);

    localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q;

    // Count 0..TICK_CYCLES-1 and pulse tick on the wrap.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            cnt_q <= '0;
            tick  <= 1'b0;
        end else if (cnt_q == CNT_W'(TICK_CYCLES - 1)) begin
            cnt_q <= '0;
            tick  <= 1'b1;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            tick  <= 1'b0;
        end
    end

endmodule

// File: rtl/traffic_scheduler.sv
// Car-lane sequencer: on each movement tick, sweeps the lanes one per cycle,
// steps each enabled car along its row and reports frog/car collisions.
//
// Config handshake: a write transfers on any rising edge where cfg_valid and
// cfg_ready are both high. cfg_ready is high only while the sweep FSM is idle;
// the master holds cfg_valid and the cfg_* fields stable until the transfer.
// Writes to lanes >= NUM_LANES transfer but change nothing.
module traffic_scheduler
    import frogger_pkg::*;
#(
    parameter int NUM_LANES   = 4,
    parameter int TICK_CYCLES = 5000000
) (
    input  logic                         i_Clk,
    input  logic                         i_Rst_n,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic [2:0]                   cfg_lane,
    input  logic [ROW_W-1:0]             cfg_row,
    input  logic                         cfg_dir,
    input  logic [PERIOD_W-1:0]          cfg_period,
    input  logic                         cfg_enable,
    input  logic [COL_W-1:0]             frog_x,
    input  logic [ROW_W-1:0]             frog_y,
    output logic [COL_W*NUM_LANES-1:0]   car_x,
    output logic [ROW_W*NUM_LANES-1:0]   car_row,
    output logic [NUM_LANES-1:0]         car_en,
    output logic [NUM_LANES-1:0]         step,
    output logic                         collision,
    output logic                         sweep_done,
    output logic                         overrun,
    output sched_state_t                 dbg_state
);

    localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    sched_state_t          state_q;
    sched_state_t          state_d;
    logic [LANE_W-1:0]     idx_q;
    logic                  tick;
    logic                  tick_pending_q;
    logic                  hit_q;

    logic [COL_W-1:0]      x_q   [NUM_LANES];
    logic [ROW_W-1:0]      row_q [NUM_LANES];
    logic [PERIOD_W-1:0]   per_q [NUM_LANES];
    logic [PERIOD_W-1:0]   cnt_q [NUM_LANES];
    logic [NUM_LANES-1:0]  dir_q;
    logic [NUM_LANES-1:0]  en_q;

    logic                  cfg_fire;
    logic                  cfg_apply;
    logic [LANE_W-1:0]     cfg_sel;
    logic                  start_sweep;
    logic                  last_lane;
    logic                  lane_active;
    logic                  lane_step;
    logic [COL_W-1:0]      lane_x_new;
    logic                  lane_hit;

    tick_gen #(
        .TICK_CYCLES (TICK_CYCLES)
    ) u_tick_gen (
        .i_Clk   (i_Clk),
        .i_Rst_n (i_Rst_n),
        .tick    (tick)
    );

    assign cfg_ready = (state_q == IDLE);
    assign dbg_state = state_q;
    assign car_en    = en_q;

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_pack
        assign car_x[k*COL_W +: COL_W]   = x_q[k];
        assign car_row[k*ROW_W +: ROW_W] = row_q[k];
    end

    // Handshake decode and sweep sequencing conditions. A tick arriving in
    // IDLE starts the sweep directly so lane 0 is processed the next cycle.
    always_comb begin
        cfg_fire    = cfg_valid && (state_q == IDLE);
        cfg_apply   = cfg_fire && (32'(cfg_lane) < NUM_LANES);
        cfg_sel     = cfg_lane[LANE_W-1:0];
        start_sweep = (state_q == IDLE) && (tick || tick_pending_q);
        last_lane   = (idx_q == LANE_W'(NUM_LANES - 1));
    end

    // Per-lane datapath for the lane currently addressed by idx_q.
    always_comb begin
        lane_active = (state_q == SWEEP) && en_q[idx_q];
        lane_step   = 1'b0;
        lane_x_new  = x_q[idx_q];
        lane_hit    = 1'b0;
        if (lane_active) begin
            if (cnt_q[idx_q] == PERIOD_W'(1)) begin
                lane_step  = 1'b1;
                lane_x_new = next_col(x_q[idx_q], dir_q[idx_q]);
            end
            lane_hit = (row_q[idx_q] == frog_y) && (lane_x_new == frog_x);
        end
    end

    // Sweep FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_sweep) state_d = SWEEP;
            SWEEP:   if (last_lane)   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM state, lane index, tick bookkeeping and collision/result flags.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            tick_pending_q <= 1'b0;
            hit_q          <= 1'b0;
            collision      <= 1'b0;
            sweep_done     <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            state_q    <= state_d;
            sweep_done <= (state_q == DONE);

            if (start_sweep) begin
                idx_q <= '0;
            end else if ((state_q == SWEEP) && !last_lane) begin
                idx_q <= idx_q + LANE_W'(1);
            end

            // Only one tick is remembered while busy; extras are lost but flagged.
            if (state_q == IDLE) begin
                tick_pending_q <= 1'b0;
            end else if (tick) begin
                tick_pending_q <= 1'b1;
                overrun        <= 1'b1;
            end

            if (state_q == SWEEP) begin
                hit_q <= hit_q | lane_hit;
            end else if (state_q == DONE) begin
                collision <= hit_q;
                hit_q     <= 1'b0;
            end
        end
    end

    // Lane configuration registers, movement counters, positions and step pulses.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                x_q[k]   <= '0;
                row_q[k] <= '0;
                per_q[k] <= PERIOD_W'(1);
                cnt_q[k] <= PERIOD_W'(1);
            end
            dir_q <= '0;
            en_q  <= '0;
            step  <= '0;
        end else begin
            step <= '0;
            if (cfg_apply) begin
                row_q[cfg_sel] <= cfg_row;
                dir_q[cfg_sel] <= cfg_dir;
                en_q[cfg_sel]  <= cfg_enable;
                per_q[cfg_sel] <= eff_period(cfg_period);
                cnt_q[cfg_sel] <= eff_period(cfg_period);
                x_q[cfg_sel]   <= cfg_dir ? COL_MAX : '0;
            end else if (lane_active) begin
                if (lane_step) begin
                    cnt_q[idx_q] <= per_q[idx_q];
                    x_q[idx_q]   <= lane_x_new;
                    step[idx_q]  <= 1'b1;
                end else begin
                    cnt_q[idx_q] <= cnt_q[idx_q] - PERIOD_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_traffic_scheduler.sv
// Directed bench for traffic_scheduler: stepping, periods, wrap, collision,
// handshake stalls, tick/write overlap, overrun and mid-sweep reset.
module tb_traffic_scheduler;

    localparam int NL = 4;
    localparam int TC = 8;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic            cfg_valid  = 1'b0;
    logic            cfg_ready;
    logic [2:0]      cfg_lane   = '0;
    logic [3:0]      cfg_row    = '0;
    logic            cfg_dir    = 1'b0;
    logic [3:0]      cfg_period = '0;
    logic            cfg_enable = 1'b0;
    logic [4:0]      frog_x     = 5'd0;
    logic [3:0]      frog_y     = 4'd14;
    logic [5*NL-1:0] car_x;
    logic [4*NL-1:0] car_row;
    logic [NL-1:0]   car_en;
    logic [NL-1:0]   step;
    logic            collision;
    logic            sweep_done;
    logic            overrun;
    frogger_pkg::sched_state_t dbg_state;

    logic            o_cfg_ready;
    logic [5*NL-1:0] o_car_x;
    logic [4*NL-1:0] o_car_row;
    logic [NL-1:0]   o_car_en;
    logic [NL-1:0]   o_step;
    logic            o_collision;
    logic            o_sweep_done;
    logic            o_overrun;
    frogger_pkg::sched_state_t o_dbg_state;

    traffic_scheduler #(.NUM_LANES(NL), .TICK_CYCLES(TC)) dut (
        .i_Clk(clk), .i_Rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_lane(cfg_lane),
        .cfg_row(cfg_row), .cfg_dir(cfg_dir), .cfg_period(cfg_period),
        .cfg_enable(cfg_enable), .frog_x(frog_x), .frog_y(frog_y),
        .car_x(car_x), .car_row(car_row), .car_en(car_en), .step(step),
        .collision(collision), .sweep_done(sweep_done), .overrun(overrun),
        .dbg_state(dbg_state)
    );

    // Ticks faster than a sweep can finish: must flag overrun.
    traffic_scheduler #(.NUM_LANES(NL), .TICK_CYCLES(NL + 1)) dut_ovr (
        .i_Clk(clk), .i_Rst_n(rst_n),
        .cfg_valid(1'b0), .cfg_ready(o_cfg_ready), .cfg_lane(3'd0),
        .cfg_row(4'd0), .cfg_dir(1'b0), .cfg_period(4'd0),
        .cfg_enable(1'b0), .frog_x(5'd0), .frog_y(4'd0),
        .car_x(o_car_x), .car_row(o_car_row), .car_en(o_car_en), .step(o_step),
        .collision(o_collision), .sweep_done(o_sweep_done), .overrun(o_overrun),
        .dbg_state(o_dbg_state)
    );

    // ---------------- scoreboard ----------------
    int         checks   = 0;
    int         failures = 0;
    logic [4:0] exp_q[$];
    int         step_cnt [NL];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] lx(input int k);
        return car_x[k*5 +: 5];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [2:0] lane, input logic [3:0] row, input logic dir,
                             input logic [3:0] per, input logic en, output int waited);
        cfg_valid  = 1'b1;
        cfg_lane   = lane;
        cfg_row    = row;
        cfg_dir    = dir;
        cfg_period = per;
        cfg_enable = en;
        waited     = 0;
        while (!cfg_ready && waited < 40) begin
            cyc();
            waited++;
        end
        if (!cfg_ready) check_eq("cfg_write_timeout", 32'(cfg_ready), 1);
        cyc();
        cfg_valid = 1'b0;
    endtask

    task automatic wait_sweep();
        int n;
        n = 0;
        for (int k = 0; k < NL; k++) step_cnt[k] = 0;
        do begin
            cyc();
            n++;
            for (int k = 0; k < NL; k++) step_cnt[k] += int'(step[k]);
        end while (!sweep_done && n < 40);
        if (!sweep_done) check_eq("sweep_timeout", 32'(sweep_done), 1);
    endtask

    task automatic wait_busy();
        int n;
        n = 0;
        while (cfg_ready && n < 40) begin
            cyc();
            n++;
        end
        if (cfg_ready) check_eq("busy_timeout", 32'(cfg_ready), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int w;
        int first_step [NL];
        int done_at;
        int dones;

        // Reset state
        repeat (3) cyc();
        check_eq("rst_cfg_ready", 32'(cfg_ready), 1);
        check_eq("rst_state", 32'(dbg_state), 32'(frogger_pkg::IDLE));
        check_eq("rst_car_x", 32'(car_x), 0);
        check_eq("rst_car_row", 32'(car_row), 0);
        check_eq("rst_car_en", 32'(car_en), 0);
        check_eq("rst_step", 32'(step), 0);
        check_eq("rst_collision", 32'(collision), 0);
        check_eq("rst_sweep_done", 32'(sweep_done), 0);
        check_eq("rst_overrun", 32'(overrun), 0);
        check_eq("rst_ovr_overrun", 32'(o_overrun), 0);
        rst_n = 1'b1;

        // Lane 0, period 1, left to right; write to lane 5 is discarded
        cfg_write(3'd0, 4'd3, 1'b0, 4'd1, 1'b1, w);
        check_eq("a_en", 32'(car_en), 32'h1);
        check_eq("a_row0", 32'(car_row[3:0]), 3);
        check_eq("a_x0_init", 32'(lx(0)), 0);
        cfg_write(3'd5, 4'd9, 1'b1, 4'd2, 1'b1, w);
        check_eq("a_bad_lane_en", 32'(car_en), 32'h1);
        check_eq("a_bad_lane_row", 32'(car_row), 32'h0003);
        for (int s = 1; s <= 2; s++) begin
            wait_sweep();
            check_eq("a_x0", 32'(lx(0)), s);
            check_eq("a_step0_cnt", step_cnt[0], 1);
        end

        // Lane 1, period 3, right to left
        cfg_write(3'd1, 4'd7, 1'b1, 4'd3, 1'b1, w);
        check_eq("b_x1_init", 32'(lx(1)), 19);
        check_eq("b_row1", 32'(car_row[7:4]), 7);
        exp_q.push_back(5'd19); exp_q.push_back(5'd19); exp_q.push_back(5'd18);
        exp_q.push_back(5'd18); exp_q.push_back(5'd18); exp_q.push_back(5'd17);
        for (int s = 1; s <= 6; s++) begin
            wait_sweep();
            check_eq("b_x1", 32'(lx(1)), 32'(exp_q.pop_front()));
            check_eq("b_step1_cnt", step_cnt[1], (s % 3 == 0) ? 1 : 0);
        end
        check_eq("b_x0", 32'(lx(0)), 8);
        check_eq("b_collision", 32'(collision), 0);

        // Wrap both directions, period 0 as 1, collision set then cleared
        frog_x = 5'd5;
        frog_y = 4'd3;
        cfg_write(3'd0, 4'd3, 1'b0, 4'd0, 1'b1, w);
        cfg_write(3'd1, 4'd7, 1'b1, 4'd1, 1'b1, w);
        for (int s = 1; s <= 20; s++) begin
            wait_sweep();
            check_eq("c_x0", 32'(lx(0)), s % 20);
            check_eq("c_x1", 32'(lx(1)), 19 - (s % 20));
            if (s == 4) check_eq("c_collision_before", 32'(collision), 0);
            if (s == 5) begin
                check_eq("c_collision_hit", 32'(collision), 1);
                frog_y = 4'd4;
            end
            if (s == 6) check_eq("c_collision_clear", 32'(collision), 0);
        end

        // Write held through a sweep: stalls NUM_LANES+1 cycles
        wait_busy();
        cfg_write(3'd2, 4'd10, 1'b0, 4'd2, 1'b1, w);
        check_eq("d_stall_cycles", w, NL + 1);
        check_eq("d_en", 32'(car_en), 32'h7);
        check_eq("d_x2", 32'(lx(2)), 0);
        check_eq("d_row2", 32'(car_row[11:8]), 10);

        // Write coincident with tick: new lane 3 moves in that sweep
        wait_sweep();
        cyc();
        cyc();
        cfg_write(3'd3, 4'd12, 1'b1, 4'd1, 1'b1, w);
        for (int k = 0; k < NL; k++) first_step[k] = -1;
        done_at = -1;
        for (int i = 1; i <= 5; i++) begin
            cyc();
            for (int k = 0; k < NL; k++)
                if (step[k] && first_step[k] < 0) first_step[k] = i;
            if (sweep_done && done_at < 0) done_at = i;
        end
        check_eq("e_step0_at", first_step[0], 1);
        check_eq("e_step1_at", first_step[1], 2);
        check_eq("e_step2_at", first_step[2], 3);
        check_eq("e_step3_at", first_step[3], 4);
        check_eq("e_done_at", done_at, 5);
        check_eq("e_x3", 32'(lx(3)), 18);
        check_eq("e_x2", 32'(lx(2)), 1);
        check_eq("e_en", 32'(car_en), 32'hF);
        check_eq("e_overrun", 32'(overrun), 0);
        check_eq("e_ovr_overrun", 32'(o_overrun), 1);

        // Collision, then reset in the middle of the next sweep
        frog_x = 5'd1;
        frog_y = 4'd3;
        cfg_write(3'd0, 4'd3, 1'b0, 4'd1, 1'b1, w);
        wait_sweep();
        check_eq("f_collision_pre", 32'(collision), 1);
        wait_busy();
        cyc();
        rst_n = 1'b0;
        cyc();
        check_eq("f_car_x", 32'(car_x), 0);
        check_eq("f_car_row", 32'(car_row), 0);
        check_eq("f_car_en", 32'(car_en), 0);
        check_eq("f_step", 32'(step), 0);
        check_eq("f_collision", 32'(collision), 0);
        check_eq("f_sweep_done", 32'(sweep_done), 0);
        check_eq("f_cfg_ready", 32'(cfg_ready), 1);
        check_eq("f_state", 32'(dbg_state), 32'(frogger_pkg::IDLE));
        check_eq("f_ovr_overrun", 32'(o_overrun), 0);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 7; i++) begin
            cyc();
            dones += int'(sweep_done);
        end
        check_eq("f_no_done_after_reset", dones, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/traffic_scheduler.md
# traffic_scheduler

Central sequencer for all car lanes in the Frogger playfield. It owns a shared movement prescaler and per-lane configuration (row, direction, speed, enable). On every movement tick it sweeps the lanes one per cycle, steps each car along its 20-column row with wrap-around, and flags a frog/car collision. It sits between the game-control FSM, which writes the lane configuration, and the per-lane car renderers, which consume `car_x` and `car_row`.

## Interface
- `NUM_LANES`, 4: number of car lanes (1..8).
- `TICK_CYCLES`, 5000000: clock cycles per movement tick (≥ NUM_LANES+2).
- `i_Clk` in 1: system clock.
- `i_Rst_n` in 1: reset. Synchronous, active-low.
- `cfg_valid` in 1: configuration write request.
- `cfg_ready` out 1: the scheduler can accept a configuration write.
- `cfg_lane` in 3: lane index of the write. Values ≥ NUM_LANES are accepted and discarded.
- `cfg_row` in 4: grid row of the lane (0..14).
- `cfg_dir` in 1: 0 = left→right, 1 = right→left.
- `cfg_period` in 4: ticks per step. 0 is treated as 1.
- `cfg_enable` in 1: lane active.
- `frog_x` in 5: frog column (0..19).
- `frog_y` in 4: frog row (0..14).
- `car_x` out 5*NUM_LANES: packed car columns, lane 0 in bits [4:0].
- `car_row` out 4*NUM_LANES: packed lane rows.
- `car_en` out NUM_LANES: lane enable flags.
- `step` out NUM_LANES: 1-cycle pulse when that lane's car moved.
- `collision` out 1: registered flag, valid from each sweep's DONE cycle onward.
- `sweep_done` out 1: 1-cycle pulse on the DONE cycle.
- `overrun` out 1: sticky flag; a tick arrived while a sweep was in progress.

## Operation
- Reset values: all `car_x`=0, `car_row`=0, `car_en`=0, periods=1, lane counters=1, `step`=0, `collision`=0, `sweep_done`=0, `overrun`=0. The FSM is in IDLE and `cfg_ready`=1.
- Prescaler: counts 0..TICK_CYCLES-1 and emits `tick` on wrap. A `tick` sets `tick_pending`.
- FSM states:
  - IDLE: `cfg_ready`=1. If `tick_pending`, clear it, set lane index to 0, and go to SWEEP.
  - SWEEP: process lane `idx` in one cycle. If `idx`=NUM_LANES-1, go to DONE; otherwise increment `idx`.
  - DONE: drive `sweep_done` and update `collision`, then go to IDLE.
- Lane processing:
  - Disabled lanes are skipped; their counter and position do not change.
  - For an enabled lane, if its counter = 1, reload the counter with the effective period and step the car:
    - dir 0: `car_x` = `car_x`==19 ? 0 : `car_x`+1.
    - dir 1: `car_x` = `car_x`==0 ? 19 : `car_x`-1.
    - Pulse `step[idx]`.
  - Otherwise decrement the counter.
- Collision:
  - During SWEEP, accumulate `hit` |= enabled && row==frog_y && post-update car_x==frog_x.
  - In DONE, `collision` <= `hit`, then `hit` is cleared.
  - Frog inputs are sampled in each lane's slot.
- Configuration write: occurs when `cfg_valid` && `cfg_ready` (IDLE only). The addressed lane's row, dir, period and enable are loaded.
  - The lane's counter is loaded with the effective period.
  - `car_x` resets to 0 (dir 0) or 19 (dir 1).
- Simultaneous write and tick in IDLE: the write is applied and the tick is latched in `tick_pending`. SWEEP starts the following cycle and sees the new configuration.
- Tick during SWEEP/DONE: set `tick_pending` and set `overrun`. At most one pending tick is kept; further ticks are lost. `overrun` is cleared only by reset.
- A write with `cfg_lane` ≥ NUM_LANES completes the handshake with no state change.
- Reset asserted mid-sweep: next cycle all state equals reset values. A partially swept frame is abandoned, with no `sweep_done` and no `step`.

## Timing
- Tick to first lane update: tick at cycle T gives IDLE→SWEEP at T+1, and lane 0 is processed at T+1.
- `car_x[k]` and `step[k]` become visible at T+2+k.
- `sweep_done` and `collision` update at T+2+NUM_LANES.
- `cfg_ready` is low for NUM_LANES+1 cycles per sweep.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `frogger_pkg`:
  - GRID_COLS=20, GRID_ROWS=15, CELL_PX=32.
  - COL_W=5, ROW_W=4, PERIOD_W=4.
  - FSM state encoding {IDLE, SWEEP, DONE}.
- Sub-module `tick_gen` (parameter TICK_CYCLES; ports i_Clk, i_Rst_n, tick), reused by the frog and log controllers.
- Lane state is held as per-lane register arrays indexed by `idx`.

## Test plan
- Reset, then write lane 0 {row 3, dir 0, period 1, en 1}, with TICK_CYCLES=8 → `car_x[0]` steps 0→1→2 on successive sweeps. `step[0]` pulses once per sweep.
- Lane 1 {dir 1, period 3}, 6 ticks → `car_x[1]`: 19, 19, 18, 18, 18, 17 (steps on ticks 3 and 6).
- Wrap: lane 0 dir 0 from 19 → next step gives 0. Lane 1 dir 1 from 0 → 19. Period 0 behaves as period 1.
- Frog (5,3), lane 0 row 3 reaching car_x=5 → `collision`=1 on that sweep's `sweep_done`. Frog moved to row 4 → `collision`=0 on the next sweep.
- `cfg_valid` held during a sweep → `cfg_ready`=0 until IDLE, write accepted in the first IDLE cycle. Simultaneous tick and write → new configuration is used in that sweep.
- TICK_CYCLES=NUM_LANES+1 → `overrun`=1. Reset asserted mid-SWEEP → all outputs at reset values on the next cycle, and no `sweep_done`.
